text_console_ctrl: RTL and testbench

Character-stream terminal controller that fills the 80x25 text RAM read by the VGA text renderer. Accepts bytes over a valid/ready handshake and tracks the cursor. Issues one-cell writes to the RAM write port. Scrolls with a hardware row-base offset instead of copying memory. The row-base offset is exported so the display address path can rotate rows.

---
 rtl/console_pkg.sv | 25 ++
 rtl/text_console_ctrl_if.sv | 22 ++
 rtl/console_addr.sv | 23 ++
 rtl/text_console_ctrl.sv | 179 +++++++++++++++++
 tb/tb_text_console_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/console_pkg.sv
// Shared constants, control codes and FSM state type for the text console.
package console_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 25;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned TAB_W  = 8;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

endpackage

// File: rtl/text_console_ctrl_if.sv
// Byte-input handshake and text RAM write port of the console controller.
interface text_console_ctrl_if;
    import console_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/console_addr.sv
// Logical (row, col) plus row base -> physical text RAM address.
module console_addr
    import console_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  base,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ROW_W:0] ROWS_EXT = (ROW_W+1)'(ROWS);

    logic [ROW_W:0]   sum;
    logic [ROW_W-1:0] phys;

    // Rotate row by base modulo ROWS, then row*80 as (r<<6)+(r<<4) plus column.
    always_comb begin
        sum  = {1'b0, row} + {1'b0, base};
        phys = (sum >= ROWS_EXT) ? ROW_W'(sum - ROWS_EXT) : sum[ROW_W-1:0];
        addr = (ADDR_W'(phys) << 6) + (ADDR_W'(phys) << 4) + ADDR_W'(col);
    end

endmodule

// File: rtl/text_console_ctrl.sv
// Character-stream terminal controller for an 80x25 text RAM.
// Scrolls by rotating row_base and clearing the newly exposed row.
// Optional: define CONSOLE_FORMFEED_EN to make 0x0C home the cursor and clear the screen.
module text_console_ctrl
    import console_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    text_console_ctrl_if.slave bus,
    output logic [ROW_W-1:0]   row_base,
    output logic [COL_W-1:0]   cursor_x,
    output logic [ROW_W-1:0]   cursor_y,
    output logic               busy
);

    state_t            state;
    logic [ROW_W-1:0]  clr_row;
    logic [COL_W-1:0]  clr_col;

    logic [ROW_W-1:0]  a_row;
    logic [COL_W-1:0]  a_col;
    logic [ROW_W-1:0]  a_base;
    logic [ADDR_W-1:0] phys_addr;

    logic              acc;
    logic [COL_W-1:0]  nx;
    logic              nl;
    logic              wr;
    logic              ff;
    logic [7:0]        tab_nx;

    assign bus.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);

    // Address source: cursor when idle, sweep counters while clearing.
    always_comb begin
        a_row  = cursor_y;
        a_col  = cursor_x;
        a_base = row_base;
        case (state)
            CLR_ALL: begin
                a_row  = clr_row;
                a_col  = clr_col;
                a_base = '0;
            end
            CLR_LINE: begin
                a_row  = ROW_W'(ROWS - 1);
                a_col  = clr_col;
            end
            default: ;
        endcase
    end

    console_addr u_addr (
        .row  (a_row),
        .col  (a_col),
        .base (a_base),
        .addr (phys_addr)
    );

    // Decode the accepted byte into cursor motion, write and newline requests.
    always_comb begin
        acc    = bus.in_valid && (state == IDLE);
        nx     = cursor_x;
        nl     = 1'b0;
        wr     = 1'b0;
        ff     = 1'b0;
        tab_nx = ({1'b0, cursor_x} | 8'(TAB_W - 1)) + 8'd1;
        if (acc) begin
            if (bus.in_data >= CH_SPACE && bus.in_data != CH_DEL) begin
                wr = 1'b1;
                if (cursor_x == COL_W'(COLS - 1)) begin
                    nx = '0;
                    nl = 1'b1;
                end else begin
                    nx = cursor_x + COL_W'(1);
                end
            end else if (bus.in_data == CH_CR) begin
                nx = '0;
            end else if (bus.in_data == CH_LF) begin
                nx = '0;
                nl = 1'b1;
            end else if (bus.in_data == CH_BS) begin
                if (cursor_x != '0) begin
                    nx = cursor_x - COL_W'(1);
                end
            end else if (bus.in_data == CH_TAB) begin
                if (tab_nx >= 8'(COLS)) begin
                    nx = '0;
                    nl = 1'b1;
                end else begin
                    nx = tab_nx[COL_W-1:0];
                end
`ifdef CONSOLE_FORMFEED_EN
            end else if (bus.in_data == CH_FF) begin
                ff = 1'b1;
`endif
            end
        end
    end

    // Controller FSM, cursor/row_base state and registered RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLR_ALL;
            clr_row       <= '0;
            clr_col       <= '0;
            row_base      <= '0;
            cursor_x      <= '0;
            cursor_y      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= CH_SPACE;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                CLR_ALL: begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= phys_addr;
                    bus.mem_wdata <= CH_SPACE;
                    if (clr_col == COL_W'(COLS - 1)) begin
                        clr_col <= '0;
                        if (clr_row == ROW_W'(ROWS - 1)) begin
                            clr_row <= '0;
                            state   <= IDLE;
                        end else begin
                            clr_row <= clr_row + ROW_W'(1);
                        end
                    end else begin
                        clr_col <= clr_col + COL_W'(1);
                    end
                end
                CLR_LINE: begin
                    bus.mem_we    <= 1'b1;
                    bus.mem_addr  <= phys_addr;
                    bus.mem_wdata <= CH_SPACE;
                    if (clr_col == COL_W'(COLS - 1)) begin
                        clr_col <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_col <= clr_col + COL_W'(1);
                    end
                end
                IDLE: begin
                    if (acc) begin
                        if (wr) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= phys_addr;
                            bus.mem_wdata <= bus.in_data;
                        end
                        if (ff) begin
                            cursor_x <= '0;
                            cursor_y <= '0;
                            row_base <= '0;
                            clr_row  <= '0;
                            clr_col  <= '0;
                            state    <= CLR_ALL;
                        end else begin
                            cursor_x <= nx;
                            if (nl) begin
                                if (cursor_y != ROW_W'(ROWS - 1)) begin
                                    cursor_y <= cursor_y + ROW_W'(1);
                                end else begin
                                    // Old top physical row becomes the new bottom row.
                                    row_base <= (row_base == ROW_W'(ROWS - 1)) ?
                                                '0 : row_base + ROW_W'(1);
                                    clr_col  <= '0;
                                    state    <= CLR_LINE;
                                end
                            end
                        end
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl.
module tb_text_console_ctrl;
    import console_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ROW_W-1:0] row_base;
    logic [COL_W-1:0] cursor_x;
    logic [ROW_W-1:0] cursor_y;
    logic             busy;

    int checks = 0;
    int errors = 0;

    text_console_ctrl_if bus ();

    text_console_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .row_base (row_base),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte on a falling edge; return #1 after the accepting rising edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        chk("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Follow a clear sequence until idle, checking sequential 0x20 writes from start.
    task automatic wait_clear(input string tag, input int start, input int n, output int bcnt);
        int wc;
        int bad;
        int cyc;
        wc = 0; bad = 0; cyc = 0; bcnt = 0;
        while ((busy || bus.mem_we) && cyc < 3000) begin
            if (busy) bcnt++;
            if (bus.mem_we) begin
                if (bus.mem_addr !== ADDR_W'(start + wc) || bus.mem_wdata !== 8'h20) bad++;
                wc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 3000), 32'd1);
        chk({tag, "_write_count"}, 32'(wc), 32'(n));
        chk({tag, "_seq_errors"}, 32'(bad), 32'd0);
        chk({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int bc;
        int bad;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'h20);
        chk("rst_row_base", 32'(row_base), 32'd0);
        chk("rst_cursor", {20'd0, 5'(cursor_y), cursor_x}, 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Full-screen clear after reset
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_all_first_we", 32'(bus.mem_we), 32'd1);
        wait_clear("clr_all", 0, 2000, bc);
        chk("clr_all_busy_low", 32'(busy), 32'd0);

        // 'A', 'B' written one cycle after acceptance
        send(8'h41);
        chk("A_we", 32'(bus.mem_we), 32'd1);
        chk("A_addr", 32'(bus.mem_addr), 32'd0);
        chk("A_data", 32'(bus.mem_wdata), 32'h41);
        send(8'h42);
        chk("B_addr", 32'(bus.mem_addr), 32'd1);
        chk("B_data", 32'(bus.mem_wdata), 32'h42);
        chk("B_cursor_x", 32'(cursor_x), 32'd2);
        @(posedge clk);
        #1;
        chk("B_we_one_cycle", 32'(bus.mem_we), 32'd0);

        // 80 printable bytes from (0,0) wrap to the next row
        send(CH_CR);
        chk("cr_no_write", 32'(bus.mem_we), 32'd0);
        chk("cr_cursor_x", 32'(cursor_x), 32'd0);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h41 + 8'(i % 26));
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== ADDR_W'(i)) bad++;
        end
        chk("row_fill_seq_errors", 32'(bad), 32'd0);
        chk("row_fill_last_addr", 32'(bus.mem_addr), 32'd79);
        chk("row_fill_cursor", {20'd0, 5'(cursor_y), cursor_x}, {20'd0, 5'd1, 7'd0});
        send(8'h43);
        chk("next_row_addr", 32'(bus.mem_addr), 32'd80);
        chk("next_row_cursor_x", 32'(cursor_x), 32'd1);

        // TAB, TAB, BS, CR, BS at column 0: no writes
        send(CH_TAB);
        chk("tab1_x", 32'(cursor_x), 32'd8);
        chk("tab1_we", 32'(bus.mem_we), 32'd0);
        send(CH_TAB);
        chk("tab2_x", 32'(cursor_x), 32'd16);
        send(CH_BS);
        chk("bs_x", 32'(cursor_x), 32'd15);
        chk("bs_we", 32'(bus.mem_we), 32'd0);
        send(CH_CR);
        chk("cr_x", 32'(cursor_x), 32'd0);
        send(CH_BS);
        chk("bs_at_zero_x", 32'(cursor_x), 32'd0);

        // Ignored control bytes
        send(8'h07);
        chk("bel_we", 32'(bus.mem_we), 32'd0);
        send(8'h7F);
        chk("del_we", 32'(bus.mem_we), 32'd0);
        chk("ignored_cursor", {20'd0, 5'(cursor_y), cursor_x}, {20'd0, 5'd1, 7'd0});

        // Walk down to the bottom row, place cursor at (5,24)
        for (int i = 0; i < 23; i++) send(CH_LF);
        chk("bottom_y", 32'(cursor_y), 32'd24);
        chk("bottom_row_base", 32'(row_base), 32'd0);
        for (int i = 0; i < 5; i++) send(8'h78);
        chk("bottom_last_addr", 32'(bus.mem_addr), 32'd1924);
        chk("bottom_cursor_x", 32'(cursor_x), 32'd5);

        // LF on the bottom row scrolls and clears physical row 0
        send(CH_LF);
        chk("scroll_row_base", 32'(row_base), 32'd1);
        chk("scroll_cursor", {20'd0, 5'(cursor_y), cursor_x}, {20'd0, 5'd24, 7'd0});
        chk("scroll_ready", 32'(bus.in_ready), 32'd0);
        chk("scroll_we", 32'(bus.mem_we), 32'd0);
        wait_clear("clr_line", 0, 80, bc);
        chk("clr_line_busy_cycles", 32'(bc), 32'd80);
        send(8'h5A);
        chk("Z_addr", 32'(bus.mem_addr), 32'd0);
        chk("Z_data", 32'(bus.mem_wdata), 32'h5A);

`ifdef CONSOLE_FORMFEED_EN
        // Form feed from row_base=3, cursor=(10,24)
        send(CH_LF);
        wait_clear("clr_line2", 80, 80, bc);
        send(CH_LF);
        wait_clear("clr_line3", 160, 80, bc);
        chk("ff_pre_row_base", 32'(row_base), 32'd3);
        send(CH_CR);
        for (int i = 0; i < 10; i++) send(8'h61);
        chk("ff_pre_cursor", {20'd0, 5'(cursor_y), cursor_x}, {20'd0, 5'd24, 7'd10});
        send(CH_FF);
        chk("ff_row_base", 32'(row_base), 32'd0);
        chk("ff_cursor", {20'd0, 5'(cursor_y), cursor_x}, 32'd0);
        chk("ff_busy", 32'(busy), 32'd1);
        chk("ff_ready", 32'(bus.in_ready), 32'd0);
        wait_clear("ff_clr_all", 0, 2000, bc);
        chk("ff_busy_cycles", 32'(bc), 32'd2000);
`else
        // Form feed is an ignored control byte in this build
        send(CH_FF);
        chk("ff_ign_we", 32'(bus.mem_we), 32'd0);
        chk("ff_ign_cursor", {20'd0, 5'(cursor_y), cursor_x}, {20'd0, 5'd24, 7'd1});
        chk("ff_ign_row_base", 32'(row_base), 32'd1);
        chk("ff_ign_busy", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
